// File: rtl/dmem_arb_defs.sv
// Shared definitions for the DMEM arbiter: FSM encodings, port ids, default
// data-segment geometry and the data-segment range test.
package dmem_arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int unsigned DEF_DEPTH_WORDS = 2048;

  // Offsets below the base wrap to large values, so one unsigned compare
  // catches both ends of the segment.
  function automatic logic off_out_of_range(input logic [31:0] off,
                                            input int unsigned depth_words);
    logic [32:0] limit;
    limit = 33'(depth_words) * 33'd4;
    return ({1'b0, off} >= limit);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request always wins; on a tie the port
// that did not win the last contended grant is chosen.
module rr_pick2
  import dmem_arb_defs::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = PORT_A;
    if (req_a && req_b) begin
      gnt_id = ~last_grant;
    end else if (req_b) begin
      gnt_id = PORT_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU (port A) and a
// loader/debug master (port B). Optional range check: DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk_in,
  input  logic        reset,
  // Handshake: req is held until the one-cycle ack; rdata/err are valid only
  // while ack is high. A req still high in the next IDLE is a new request.
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ack,
  output logic        b_err,
  output logic        dm_cs,
  output logic        dm_r,
  output logic        dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        gnt_valid, gnt_id;

  logic        lat_id, lat_we, lat_err;
  logic [31:0] lat_off, lat_wdata;

  logic        win_we, win_err;
  logic [31:0] win_addr, win_wdata, win_off;
  logic [31:0] rd_val;

  rr_pick2 u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Winner's request, as sampled in IDLE.
  always_comb begin
    win_we    = (gnt_id == PORT_B) ? b_we    : a_we;
    win_addr  = (gnt_id == PORT_B) ? b_addr  : a_addr;
    win_wdata = (gnt_id == PORT_B) ? b_wdata : a_wdata;
    win_off   = win_addr - BASE_ADDR;
    win_err   = RANGE_EN & off_out_of_range(win_off, DEPTH_WORDS);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = SERVE;
      SERVE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DMEM sees strobes only in SERVE, and only for in-range requests.
  always_comb begin
    dm_cs    = 1'b0;
    dm_r     = 1'b0;
    dm_w     = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    if (state_q == SERVE && !lat_err) begin
      dm_cs    = 1'b1;
      dm_w     = lat_we;
      dm_r     = ~lat_we;
      dm_addr  = lat_off;
      dm_wdata = lat_wdata;
    end
  end

  assign rd_val    = (lat_we || lat_err) ? 32'h0 : dm_rdata;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_B;
      lat_id       <= PORT_A;
      lat_we       <= 1'b0;
      lat_err      <= 1'b0;
      lat_off      <= 32'h0;
      lat_wdata    <= 32'h0;
      a_ack        <= 1'b0;
      a_err        <= 1'b0;
      a_rdata      <= 32'h0;
      b_ack        <= 1'b0;
      b_err        <= 1'b0;
      b_rdata      <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            lat_id    <= gnt_id;
            lat_we    <= win_we;
            lat_err   <= win_err;
            lat_off   <= win_off;
            lat_wdata <= win_wdata;
            // Fairness history only moves on a contended grant.
            if (a_req && b_req) last_grant_q <= gnt_id;
          end
        end
        SERVE: begin
          if (lat_id == PORT_A) begin
            a_ack   <= 1'b1;
            a_err   <= lat_err;
            a_rdata <= rd_val;
          end else begin
            b_ack   <= 1'b1;
            b_err   <= lat_err;
            b_rdata <= rd_val;
          end
        end
        default: begin
          a_ack   <= 1'b0;
          a_err   <= 1'b0;
          a_rdata <= 32'h0;
          b_ack   <= 1'b0;
          b_err   <= 1'b0;
          b_rdata <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural DMEM model.
module tb_dmem_arbiter;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic [31:0] a_rdata, b_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        a_ack, a_err, b_ack, b_err, dm_cs, dm_r, dm_w, busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Ack scoreboard entry: {port, err, rdata}; DMEM scoreboard: {we, addr, wdata}.
  logic [33:0] exp_q[$];
  logic [64:0] exp_dm_q[$];

  logic [31:0] mem [0:2047];
  logic        init_mem = 1'b1;

  always #5 clk_in = ~clk_in;

  dmem_arbiter dut (
    .clk_in (clk_in), .reset (reset),
    .a_req (a_req), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
    .a_rdata (a_rdata), .a_ack (a_ack), .a_err (a_err),
    .b_req (b_req), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
    .b_rdata (b_rdata), .b_ack (b_ack), .b_err (b_err),
    .dm_cs (dm_cs), .dm_r (dm_r), .dm_w (dm_w), .dm_addr (dm_addr),
    .dm_wdata (dm_wdata), .dm_rdata (dm_rdata), .busy (busy),
    .dbg_state (dbg_state)
  );

  assign dm_rdata = mem[dm_addr[12:2]];

  always @(posedge clk_in) begin
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'hDEAD_BEEF;
      mem[1]    <= 32'h1111_1111;
      mem[2]    <= 32'h2222_2222;
      mem[2047] <= 32'hCAFE_F00D;
    end else if (dm_cs && dm_w) begin
      mem[dm_addr[12:2]] <= dm_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ack monitor.
  always @(negedge clk_in) begin
    if (a_ack || b_ack) begin
      logic [33:0] e;
      checks++;
      if (a_ack && b_ack) begin
        errors++;
        $display("FAIL two_acks: a_ack=%b b_ack=%b expected one", a_ack, b_ack);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: a_ack=%b b_ack=%b expected none", a_ack, b_ack);
      end else begin
        e = exp_q.pop_front();
        if (e[33] == 1'b0) begin
          if (!a_ack || a_err !== e[32] || a_rdata !== e[31:0]) begin
            errors++;
            $display("FAIL ack_a: ack=%b err=%b rdata=%h expected ack=1 err=%b rdata=%h",
                     a_ack, a_err, a_rdata, e[32], e[31:0]);
          end
        end else begin
          if (!b_ack || b_err !== e[32] || b_rdata !== e[31:0]) begin
            errors++;
            $display("FAIL ack_b: ack=%b err=%b rdata=%h expected ack=1 err=%b rdata=%h",
                     b_ack, b_err, b_rdata, e[32], e[31:0]);
          end
        end
      end
    end
  end

  // DMEM monitor.
  always @(negedge clk_in) begin
    if (dm_cs) begin
      logic [64:0] d;
      checks++;
      if (exp_dm_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dm: we=%b addr=%h expected no access", dm_w, dm_addr);
      end else begin
        d = exp_dm_q.pop_front();
        if (dm_w !== d[64] || dm_r !== ~d[64] || dm_addr !== d[63:32] || dm_wdata !== d[31:0]) begin
          errors++;
          $display("FAIL dm_access: w=%b r=%b addr=%h wdata=%h expected w=%b addr=%h wdata=%h",
                   dm_w, dm_r, dm_addr, dm_wdata, d[64], d[63:32], d[31:0]);
        end
      end
    end else if (dm_r || dm_w || dm_addr != 32'h0 || dm_wdata != 32'h0) begin
      errors++;
      $display("FAIL dm_idle: r=%b w=%b addr=%h wdata=%h expected all 0", dm_r, dm_w, dm_addr, dm_wdata);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One transaction on a single port; returns at the negedge of its ack cycle.
  task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_dm_addr,
                     input logic [31:0] exp_rdata, input logic exp_err);
    bit seen = 0;
    exp_q.push_back({port, exp_err, exp_rdata});
    if (!exp_err) exp_dm_q.push_back({we, exp_dm_addr, wdata});
    if (port == 1'b0) begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end else begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_in);
      if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) seen = 1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: port=%0d got no ack expected ack within 20 cycles", port);
    end
  endtask

  initial begin
    int n;
    bit done;
    repeat (3) tick();
    init_mem = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", {28'h0, a_ack, b_ack, a_err, b_err}, 32'h0);
    chk("rst_rdata", a_rdata | b_rdata, 32'h0);
    chk("rst_dm", {27'h0, dm_cs, dm_r, dm_w, 2'b0} | dm_addr | dm_wdata, 32'h0);
    reset = 1'b0;
    tick();

    // Both requesters held from the first IDLE: A first, then strict alternation.
    exp_q.push_back({1'b0, 1'b0, 32'h1111_1111});
    exp_q.push_back({1'b1, 1'b0, 32'h2222_2222});
    exp_q.push_back({1'b0, 1'b0, 32'h1111_1111});
    exp_q.push_back({1'b1, 1'b0, 32'h2222_2222});
    for (int i = 0; i < 2; i++) begin
      exp_dm_q.push_back({1'b0, 32'h4, 32'hAAAA_0000});
      exp_dm_q.push_back({1'b0, 32'h8, 32'hBBBB_0000});
    end
    a_we = 1'b0; a_addr = 32'h1001_0004; a_wdata = 32'hAAAA_0000; a_req = 1'b1;
    b_we = 1'b0; b_addr = 32'h1001_0008; b_wdata = 32'hBBBB_0000; b_req = 1'b1;
    n = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_in);
      if (a_ack || b_ack) n++;
      if (n == 4) done = 1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("contention_acks", 32'(n), 32'd4);

    txn(1'b0, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn(1'b1, 1'b1, 32'h1001_0010, 32'h1234_5678, 32'h10, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 32'h1001_0010, 32'h0, 32'h10, 32'h1234_5678, 1'b0);
    txn(1'b0, 1'b1, 32'h1001_0023, 32'hA5A5_5A5A, 32'h23, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 32'h1001_0020, 32'h0, 32'h20, 32'hA5A5_5A5A, 1'b0);
    txn(1'b1, 1'b0, 32'h1001_1FFC, 32'h0, 32'h1FFC, 32'hCAFE_F00D, 1'b0);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    txn(1'b0, 1'b0, 32'h1001_2000, 32'h0, 32'h0, 32'h0, 1'b1);
    txn(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 32'h0, 1'b1);
`else
    txn(1'b0, 1'b0, 32'h1001_2000, 32'h0, 32'h2000, 32'hDEAD_BEEF, 1'b0);
    txn(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b0);
`endif

    // Reset while in SERVE: the strobe occurs, the ack never does.
    tick();
    exp_dm_q.push_back({1'b0, 32'h4, 32'h0});
    a_we = 1'b0; a_addr = 32'h1001_0004; a_wdata = 32'h0; a_req = 1'b1;
    tick();
    chk("mid_serve_state", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    a_req = 1'b0;
    tick();
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_ack", {30'h0, a_ack, b_ack}, 32'h0);
    chk("mid_rst_dm", {29'h0, dm_cs, dm_r, dm_w} | dm_addr, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    txn(1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    repeat (4) tick();
    chk("ack_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("dm_queue_empty", 32'(exp_dm_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
